// File: rtl/uart_alu_if_pkg.sv
// Shared types and defaults for the UART-to-ALU frame interface.
// The timed-out-frame feature is enabled by defining UART_ALU_IF_TIMEOUT_EN.
package uart_alu_if_pkg;

  localparam int DATA_LEN_DEFAULT   = 8;
  localparam int OPCODE_LEN_DEFAULT = 6;

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  // A byte is taken only while collecting a frame, or in WAIT_TX when the
  // transmitter finishes in the same cycle; anywhere else it is an overrun.
  function automatic logic accepts_byte(input state_t s, input logic tx_done);
    return (s == WAIT_A) || (s == WAIT_B) || (s == WAIT_OP) ||
           ((s == WAIT_TX) && tx_done);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Idle-cycle counter that abandons a partial frame; only built when
// UART_ALU_IF_TIMEOUT_EN is defined.
`ifdef UART_ALU_IF_TIMEOUT_EN
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expired = (count == LAST);

  // Saturates at LAST so expired stays asserted until the next accepted byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/uart_alu_if.sv
// Collects A, B and opcode bytes from a UART receiver, latches the ALU result
// and hands it to the transmitter. Optional frame timeout: UART_ALU_IF_TIMEOUT_EN.
module uart_alu_if
  import uart_alu_if_pkg::*;
#(
  parameter int NBIT_DATA_LEN  = DATA_LEN_DEFAULT,
  parameter int NBIT_OPCODE    = OPCODE_LEN_DEFAULT,  // must not exceed NBIT_DATA_LEN
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0] rx_data_in,
  input  logic [NBIT_DATA_LEN-1:0] alu_data_in,
  input  logic                     tx_done_tick,
  output logic [NBIT_DATA_LEN-1:0] A,
  output logic [NBIT_DATA_LEN-1:0] B,
  output logic [NBIT_OPCODE-1:0]   OPCODE,
  output logic [NBIT_DATA_LEN-1:0] data_out,
  output logic                     tx_start,
  output logic                     busy,
  output logic                     rx_overrun,
  output logic                     frame_timeout
);

  state_t state;
  logic   byte_accepted;
  logic   timer_expired;

  assign byte_accepted = rx_done_tick && accepts_byte(state, tx_done_tick);
  assign busy          = (state != WAIT_A);

`ifdef UART_ALU_IF_TIMEOUT_EN
  logic timer_enable;
  logic frame_timeout_q;

  assign timer_enable  = (state == WAIT_B) || (state == WAIT_OP);
  assign frame_timeout = frame_timeout_q;

  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (byte_accepted),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // A byte arriving on the expiry cycle wins, so no pulse is raised then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_timeout_q <= 1'b0;
    end else begin
      frame_timeout_q <= timer_enable && timer_expired && !rx_done_tick;
    end
  end
`else
  assign timer_expired = 1'b0;
  assign frame_timeout = 1'b0;
`endif

  // tx_start follows SEND by one edge, giving the fixed two-cycle latency
  // from the opcode byte to the transmitter start strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_A;
      A          <= '0;
      B          <= '0;
      OPCODE     <= '0;
      data_out   <= '0;
      tx_start   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      tx_start <= (state == SEND);
      if (rx_done_tick && !byte_accepted) begin
        rx_overrun <= 1'b1;
      end
      case (state)
        WAIT_A: begin
          if (byte_accepted) begin
            A     <= rx_data_in;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (byte_accepted) begin
            B     <= rx_data_in;
            state <= WAIT_OP;
          end else if (timer_expired) begin
            state <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (byte_accepted) begin
            OPCODE <= rx_data_in[NBIT_OPCODE-1:0];
            state  <= EXEC;
          end else if (timer_expired) begin
            state <= WAIT_A;
          end
        end
        EXEC: begin
          data_out <= alu_data_in;
          state    <= SEND;
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done_tick) begin
            if (byte_accepted) begin
              A     <= rx_data_in;
              state <= WAIT_B;
            end else begin
              state <= WAIT_A;
            end
          end
        end
        default: begin
          state <= WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed, table-driven bench for uart_alu_if with a small opcode-decoding
// ALU stand-in; timeout checks follow UART_ALU_IF_TIMEOUT_EN.
module tb_uart_alu_if;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data_in;
  logic [7:0] alu_data_in;
  logic       tx_done_tick;
  logic [7:0] a;
  logic [7:0] b;
  logic [5:0] opcode;
  logic [7:0] data_out;
  logic       tx_start;
  logic       busy;
  logic       rx_overrun;
  logic       frame_timeout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op_byte;
    logic [5:0] exp_op;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  // ALU stand-in: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, anything else xor.
  always_comb begin
    case (opcode)
      6'h20:   alu_data_in = a + b;
      6'h22:   alu_data_in = a - b;
      6'h24:   alu_data_in = a & b;
      6'h25:   alu_data_in = a | b;
      default: alu_data_in = a ^ b;
    endcase
  end

  uart_alu_if #(
    .NBIT_DATA_LEN (8),
    .NBIT_OPCODE   (6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data_in   (rx_data_in),
    .alu_data_in  (alu_data_in),
    .tx_done_tick (tx_done_tick),
    .A            (a),
    .B            (b),
    .OPCODE       (opcode),
    .data_out     (data_out),
    .tx_start     (tx_start),
    .busy         (busy),
    .rx_overrun   (rx_overrun),
    .frame_timeout(frame_timeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] d);
    rx_data_in   = d;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
  endtask

  task automatic pulseTxDone();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  // Runs one frame and leaves the DUT in WAIT_TX after the tx_start pulse.
  task automatic applyStimulus(input vec_t v);
    sendByte(v.a);
    sendByte(v.b);
    sendByte(v.op_byte);
    checkOutput("A", a, v.a);
    checkOutput("B", b, v.b);
    checkOutput("OPCODE", opcode, v.exp_op);
    checkOutput("tx_start_exec", tx_start, 0);
    step();
    checkOutput("tx_start_send", tx_start, 0);
    checkOutput("data_out", data_out, v.exp_res);
    step();
    checkOutput("tx_start_pulse", tx_start, 1);
    step();
    checkOutput("tx_start_after", tx_start, 0);
    checkOutput("busy_wait_tx", busy, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_timeout;
    int timeout_highs;
    logic busy_at_timeout;

    vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
    vecs[1] = '{8'h0A, 8'h04, 8'hE2, 6'h22, 8'h06};
    vecs[2] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
    vecs[3] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF};
    vecs[4] = '{8'hFF, 8'h01, 8'hE0, 6'h20, 8'h00};
    vecs[5] = '{8'h12, 8'h34, 8'hE1, 6'h21, 8'h26};

    reset        = 1'b0;
    rx_done_tick = 1'b0;
    rx_data_in   = 8'h00;
    tx_done_tick = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_A", a, 0);
    checkOutput("rst_B", b, 0);
    checkOutput("rst_OPCODE", opcode, 0);
    checkOutput("rst_data_out", data_out, 0);
    checkOutput("rst_tx_start", tx_start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overrun", rx_overrun, 0);
    checkOutput("rst_frame_timeout", frame_timeout, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    pulseTxDone();
    checkOutput("txdone_ignored_idle", busy, 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      pulseTxDone();
      checkOutput("busy_after_tx", busy, 0);
    end
    checkOutput("hold_A", a, 8'h12);
    checkOutput("hold_data_out", data_out, 8'h26);

    // Receive and transmit-done in the same cycle starts a new frame.
    applyStimulus(vecs[0]);
    rx_data_in   = 8'h11;
    rx_done_tick = 1'b1;
    tx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    checkOutput("simul_A", a, 8'h11);
    checkOutput("simul_busy", busy, 1);
    checkOutput("simul_overrun", rx_overrun, 0);
    checkOutput("simul_B_held", b, 8'h03);
    sendByte(8'h22);
    checkOutput("simul_B", b, 8'h22);
    sendByte(8'h20);
    step();
    checkOutput("simul_data_out", data_out, 8'h33);
    step();
    step();

    // Byte during WAIT_TX is dropped and flagged.
    sendByte(8'h77);
    checkOutput("ovr_flag", rx_overrun, 1);
    checkOutput("ovr_A", a, 8'h11);
    checkOutput("ovr_busy", busy, 1);
    pulseTxDone();
    checkOutput("ovr_back_idle", busy, 0);
    checkOutput("ovr_sticky", rx_overrun, 1);

    sendByte(8'h40);
    pulseTxDone();
    checkOutput("txdone_ignored_wait_b", busy, 1);
    sendByte(8'h41);
    checkOutput("wait_b_B", b, 8'h41);
    checkOutput("wait_b_A", a, 8'h40);

    // Asynchronous reset after the B byte, checked before any clock edge.
    reset = 1'b1;
    #2;
    checkOutput("midrst_A", a, 0);
    checkOutput("midrst_B", b, 0);
    checkOutput("midrst_data_out", data_out, 0);
    checkOutput("midrst_overrun", rx_overrun, 0);
    checkOutput("midrst_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus('{8'h02, 8'h02, 8'h20, 6'h20, 8'h04});
    pulseTxDone();

    // Partial frame: A byte followed by a long idle gap.
    sendByte(8'h5A);
    first_timeout   = 0;
    timeout_highs   = 0;
    busy_at_timeout = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (frame_timeout) begin
        timeout_highs++;
        if (first_timeout == 0) begin
          first_timeout   = i;
          busy_at_timeout = busy;
        end
      end
    end
`ifdef UART_ALU_IF_TIMEOUT_EN
    checkOutput("timeout_cycle", first_timeout, 16);
    checkOutput("timeout_width", timeout_highs, 1);
    checkOutput("timeout_busy", busy_at_timeout, 0);
    checkOutput("timeout_A_kept", a, 8'h5A);
    checkOutput("timeout_B_kept", b, 8'h02);
    sendByte(8'h66);
    checkOutput("timeout_next_A", a, 8'h66);
    checkOutput("timeout_next_busy", busy, 1);
`else
    checkOutput("no_timeout_pulses", timeout_highs, 0);
    checkOutput("no_timeout_busy", busy, 1);
    sendByte(8'h01);
    sendByte(8'h20);
    step();
    checkOutput("no_timeout_data_out", data_out, 8'h5B);
    step();
    step();
    pulseTxDone();
    checkOutput("no_timeout_idle", busy, 0);
`endif

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_alu_if.md
UART_ALU_IF -- requirements
Module: uart_alu_if

Interface
Parameters:
- REQ-001 The block SHALL have parameter NBIT_DATA_LEN, default 8: width of the RX byte, the ALU operands and the ALU result.
- REQ-002 The block SHALL have parameter NBIT_OPCODE, default 6: ALU opcode width; legal only when NBIT_OPCODE <= NBIT_DATA_LEN.
- REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000: idle cycles allowed between bytes of one frame.

Ports (one clock; reset is asynchronous and active-high):
- REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-005 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-006 The block SHALL have the port rx_done_tick, input, 1 bit: one-cycle strobe meaning rx_data_in is valid.
- REQ-007 The block SHALL have the port rx_data_in, input, NBIT_DATA_LEN bits: received byte.
- REQ-008 The block SHALL have the port alu_data_in, input, NBIT_DATA_LEN bits: combinational ALU result.
- REQ-009 The block SHALL have the port tx_done_tick, input, 1 bit: one-cycle strobe meaning the transmitter finished.
- REQ-010 The block SHALL have the port A, output, NBIT_DATA_LEN bits: registered operand A.
- REQ-011 The block SHALL have the port B, output, NBIT_DATA_LEN bits: registered operand B.
- REQ-012 The block SHALL have the port OPCODE, output, NBIT_OPCODE bits: registered opcode.
- REQ-013 The block SHALL have the port data_out, output, NBIT_DATA_LEN bits: latched result presented to TX.
- REQ-014 The block SHALL have the port tx_start, output, 1 bit: one-cycle start strobe to TX.
- REQ-015 The block SHALL have the port busy, output, 1 bit: high in any state other than WAIT_A.
- REQ-016 The block SHALL have the port rx_overrun, output, 1 bit: sticky flag for a byte dropped while busy.
- REQ-017 The block SHALL have the port frame_timeout, output, 1 bit: one-cycle pulse when a partial frame is abandoned.

Function
- REQ-018 The FSM SHALL have the states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND and WAIT_TX.
- REQ-019 In WAIT_A, on rx_done_tick, the block SHALL load A <= rx_data_in and go to WAIT_B.
- REQ-020 In WAIT_B, on rx_done_tick, the block SHALL load B <= rx_data_in and go to WAIT_OP.
- REQ-021 In WAIT_OP, on rx_done_tick, the block SHALL load OPCODE <= rx_data_in[NBIT_OPCODE-1:0] and go to EXEC; the upper bits are ignored.
- REQ-022 EXEC SHALL last exactly one cycle with A, B and OPCODE stable; at its end the block SHALL load data_out <= alu_data_in and go to SEND.
- REQ-023 SEND SHALL last one cycle, with tx_start registered high during it and low in every other state; the FSM then goes to WAIT_TX.
- REQ-024 Latency SHALL be fixed: opcode tick sampled at edge n gives EXEC during cycle n..n+1 and tx_start high during cycle n+2..n+3.
- REQ-025 In WAIT_TX, on tx_done_tick, the block SHALL go to WAIT_A.
- REQ-026 In WAIT_TX, if rx_done_tick and tx_done_tick arrive together, the block SHALL load A and go to WAIT_B, with no overrun.
- REQ-027 An rx_done_tick in EXEC, SEND, or WAIT_TX without tx_done_tick SHALL drop the byte and set rx_overrun, which stays set until reset.
- REQ-028 A, B, OPCODE and data_out SHALL hold their values between frames; only the field addressed by the current state is written.
- REQ-029 A tx_done_tick in any state other than WAIT_TX SHALL be ignored.

Reset
- REQ-030 Asserting reset SHALL force the FSM to WAIT_A and set A=0, B=0, OPCODE=0, data_out=0, tx_start=0, rx_overrun=0, frame_timeout=0 and the timeout counter to 0, immediately and without waiting for clk.
- REQ-031 Reset asserted mid-frame or mid-transmit SHALL discard the partial frame; the first tick after release SHALL be taken as A.

Configuration
- REQ-032 With macro UART_ALU_IF_TIMEOUT_EN defined, the timeout SHALL be active:
  - a counter clears on each accepted rx_done_tick and increments every cycle in WAIT_B or WAIT_OP;
  - on reaching TIMEOUT_CYCLES-1 the FSM returns to WAIT_A and frame_timeout pulses for one cycle;
  - A and B keep their values.
- REQ-033 Without UART_ALU_IF_TIMEOUT_EN, the timeout SHALL be absent: no counter is generated, frame_timeout is tied 0, and WAIT_B/WAIT_OP wait indefinitely.
- REQ-034 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES).

Structure
- REQ-035 Package uart_alu_if_pkg SHALL hold the state enum typedef and the default width constants (8, 6).
- REQ-036 The timeout counter SHALL be sub-module frame_timer (inputs clear, enable; output expired), instantiated only under UART_ALU_IF_TIMEOUT_EN.
- REQ-037 No other sub-modules SHALL be used.

Verification
- REQ-038 Nominal frame: ticks with 0x05, 0x03, then 0x20, with alu_data_in = A+B -> A=0x05, B=0x03, OPCODE=0x20, data_out=0x08, tx_start high exactly one cycle, two cycles after the opcode tick.
- REQ-039 Opcode truncation: opcode byte 0xE1 -> OPCODE=0x21.
- REQ-040 Overrun: a tick with 0x77 during WAIT_TX -> rx_overrun=1, A unchanged, FSM remains in WAIT_TX.
- REQ-041 Simultaneous ticks: rx 0x11 and tx_done_tick in the same cycle -> A=0x11, state WAIT_B, rx_overrun=0.
- REQ-042 Timeout (macro on, TIMEOUT_CYCLES=16): A byte, then 16 idle cycles -> frame_timeout pulses, busy=0, and the next byte loads A.
- REQ-043 Reset after the B byte -> all outputs 0 and busy=0 without waiting for clk; a frame 0x02, 0x02, 0x20 after release yields data_out=0x04.
